// File: rtl/word_serializer.sv
// Width-down serializer: one IN_W-bit word in per handshake, IN_W/OUT_W beats out
// on a valid/ready stream with a last-beat marker and selectable beat order.
module word_serializer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int N  = IN_W / OUT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((OUT_W < 1) || (IN_W < OUT_W) || ((IN_W % OUT_W) != 0)) begin : g_bad_params
    $fatal(1, "word_serializer: IN_W must be a non-zero multiple of OUT_W");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state, state_n;
  logic [IN_W-1:0] sreg, sreg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last_q, last_n;
  logic            in_accept, beat_accept;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are both
  // high; valid never drops and data never changes while waiting for ready.
  assign out_valid   = (state == SEND);
  assign busy        = out_valid;
  assign out_last    = last_q;
  assign in_ready    = !out_valid || (out_ready && last_q);
  assign in_accept   = in_valid && in_ready;
  assign beat_accept = out_valid && out_ready;
  assign out_data    = (MSB_FIRST != 0) ? sreg[IN_W-1 -: OUT_W] : sreg[OUT_W-1:0];

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    // A new word wins over retiring the last beat, which is what removes the bubble.
    if (in_accept) begin
      state_n = SEND;
      sreg_n  = in_data;
      cnt_n   = '0;
    end else if (beat_accept) begin
      if (last_q) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n  = cnt + CW'(1);
        sreg_n = (MSB_FIRST != 0) ? (sreg << OUT_W) : (sreg >> OUT_W);
      end
    end
    last_n = (state_n == SEND) && (cnt_n == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      last_q <= last_n;
    end
  end

endmodule
